ygb2_scheduler: RTL
===================

// Module: ygb2_scheduler
// PURPOSE
//  Sequencer for the YGB2 complex-MAC datapath (4x cmult Q8.8 + adder tree, real output).
//  On start, sweeps every (row, col) address pair of one frame into the datapath, one per cycle.
//  Tracks the datapath pipeline latency and captures each 16-bit result into a frame buffer.
//  Streams the results out over a valid/ready port. Backpressure never stalls the datapath.
// PARAMETERS
//  ROWS     2   Y-table rows per frame (row address range 0..ROWS-1)
//  COLS     2   column vectors per frame (col address range 0..COLS-1)
//  AW       1   address width, clog2(max(ROWS,COLS)), minimum 1
//  DW       16  result width (Q8.8, two's complement)
//  PIPE_LAT 2   cycles from an issue edge to a valid dp_result (datapath latency)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  start      in   1   begin one frame; sampled only in IDLE
//  abort      in   1   synchronous flush back to IDLE; wins over every other event
//  busy       out  1   frame in progress (ISSUE, DRAIN or OUT)
//  done       out  1   one-cycle pulse after the last result handshake
//  row_addr   out  AW  Y-table row select to datapath
//  col_addr   out  AW  column select to datapath
//  dp_issue   out  1   address pair on row/col_addr is a live issue this cycle
//  dp_result  in   DW  datapath real-sum output
//  res_valid  out  1   res_* holds a buffered result
//  res_ready  in   1   consumer accepts result when res_valid & res_ready
//  res_data   out  DW  result value
//  res_row    out  AW  row index tag of res_data
//  res_col    out  AW  col index tag of res_data
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (busy, done, dp_issue, res_valid, addrs, res_*); FIFO empty.
//  FSM IDLE -> ISSUE (start=1) -> DRAIN (last pair issued) -> OUT (tag pipe empty) -> IDLE (FIFO empty after last pop; done=1).
//  Timing reference: cycle 0 = the clk edge that samples start in IDLE.
//  ISSUE: cycles 1..N, N=ROWS*COLS, row-major with col innermost.
//   - dp_issue=1; row/col_addr advance by one pair per cycle.
//   - Counters wrap col COLS-1->0 and row++; the last pair is (ROWS-1, COLS-1).
//  Tag pipe: PIPE_LAT-deep shift register of {valid,row,col}.
//   - The issue at cycle t is captured from dp_result at edge t+PIPE_LAT and pushed into the FIFO.
//   - Capture continues through DRAIN and OUT until the tag pipe is empty.
//  FIFO: depth N. One frame in flight, so it cannot overflow. Registered output.
//   - res_valid rises the cycle after the first push.
//   - Push and pop in the same cycle are both honoured.
//  Output: res_* stay stable while res_valid=1 and res_ready=0. Pop happens only on handshake.
//  done: pulses the cycle after the N-th handshake. busy falls in that same cycle.
//  Addresses outside ISSUE hold their last value. dp_issue=0 outside ISSUE.
//  start while busy: ignored, never queued. start and abort together in IDLE: abort wins, stay IDLE.
//  abort in any state: next cycle is IDLE.
//   - Tag pipe and FIFO cleared, res_valid=0, no done pulse.
//   - Results still in flight in the datapath are discarded.
//  Asynchronous rst mid-frame: same end state as reset, immediately.
//  Arithmetic: none; dp_result is passed through bit-exact, no saturation or rounding.
// STRUCTURE
//  ygb_pkg: DW, FB=8 (Q8.8), PIPE_LAT, ROWS/COLS defaults, FSM state encoding.
//  Sub-module ygb_res_fifo: DW+2*AW wide, depth N, registered output, count-based full/empty.
//  Scheduler top: FSM, row/col counters, tag shift register, done/busy logic.
// TESTING
//  1 Stimulus: defaults, res_ready=1, bench dp_result model = 16'h0100*row + col, start at cycle 0.
//    Response: issues (0,0),(0,1),(1,0),(1,1) in cycles 1-4; res_valid cycles 4-7 with
//    data 0000, 0001, 0100, 0101 and matching tags; done=1 at cycle 8 only; busy=1 cycles 1-7.
//  2 Stimulus: res_ready=0 until cycle 12.
//    Response: FIFO holds 4 entries and res_* stay stable at 0000/(0,0); 4 pops in cycles 12-15; done at 16.
//  3 Stimulus: start pulsed again at cycles 2 and 5.
//    Response: ignored; exactly 4 issues and one done.
//  4 Stimulus: abort at cycle 3.
//    Response: IDLE at cycle 4, dp_issue=0, res_valid=0, no done.
//    Then start at cycle 6: a clean full frame with 4 correct results.
//  5 Stimulus: rst asserted mid-OUT with 2 entries buffered.
//    Response: all outputs 0 immediately; after release, a new frame behaves as in test 1.
//  6 Stimulus: ROWS=3, COLS=2, PIPE_LAT=4, random res_ready.
//    Response: 6 results in row-major order, no drops or duplicates, done after the 6th handshake.

Source files
------------

// File: rtl/ygb2_scheduler_pkg.sv
// Shared constants for the YGB2 complex-MAC scheduler: defaults, Q-format and FSM encoding.
package ygb2_scheduler_pkg;

  localparam int unsigned DefDw      = 16;
  localparam int unsigned Fb         = 8;
  localparam int unsigned DefPipeLat = 2;
  localparam int unsigned DefRows    = 2;
  localparam int unsigned DefCols    = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StOut   = 2'd3;

  function automatic int unsigned addr_width(input int unsigned rows, input int unsigned cols);
    int unsigned m;
    m = (rows > cols) ? rows : cols;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ygb2_scheduler_if.sv
// Control, datapath and result-stream signals between the scheduler and its environment.
interface ygb2_scheduler_if #(
  parameter int unsigned AW = 1,
  parameter int unsigned DW = 16
) ();

  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] row_addr;
  logic [AW-1:0] col_addr;
  logic          dp_issue;
  logic [DW-1:0] dp_result;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_row;
  logic [AW-1:0] res_col;

  modport master (
    input  start, abort, dp_result, res_ready,
    output busy, done, row_addr, col_addr, dp_issue, res_valid, res_data, res_row, res_col
  );

  modport slave (
    output start, abort, dp_result, res_ready,
    input  busy, done, row_addr, col_addr, dp_issue, res_valid, res_data, res_row, res_col
  );

endinterface

// File: rtl/ygb2_scheduler_res_fifo.sv
// Result FIFO with a registered head slot; push and pop in the same cycle are both honoured.
module ygb2_scheduler_res_fifo #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic          slot_free, mem_empty, load_mem, bypass, mem_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head slot refills from storage first; an incoming word bypasses storage only when it is empty.
  always_comb begin
    slot_free = !out_valid_q || pop;
    mem_empty = (cnt_q == '0);
    load_mem  = slot_free && !mem_empty;
    bypass    = slot_free && mem_empty && push;
    mem_wr    = push && !bypass;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (load_mem) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (mem_wr && !load_mem) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!mem_wr && load_mem) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (load_mem) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem_q[rd_ptr_q];
      end else if (bypass) begin
        out_valid_q <= 1'b1;
        out_data_q  <= push_data;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/ygb2_scheduler.sv
// Sweeps one frame of (row, col) pairs into the complex-MAC datapath, tracks its latency with a
// tag pipe and streams the captured results out over valid/ready.
module ygb2_scheduler
  import ygb2_scheduler_pkg::*;
#(
  parameter int unsigned ROWS     = DefRows,
  parameter int unsigned COLS     = DefCols,
  parameter int unsigned AW       = addr_width(ROWS, COLS),
  parameter int unsigned DW       = DefDw,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input logic              clk,
  input logic              rst,
  ygb2_scheduler_if.master bus
);

  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned FW  = DW + 2 * AW;
  localparam int unsigned NCW = $clog2(N + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  logic          done_q, done_d;
  logic [NCW-1:0] pop_cnt_q;

  logic [PIPE_LAT-1:0] tag_v_q, tag_v_d;
  logic [AW-1:0]       tag_row_q [PIPE_LAT];
  logic [AW-1:0]       tag_col_q [PIPE_LAT];

  logic          issue, last_pair, handshake, last_pop;
  logic [FW-1:0] push_data, fifo_out;

  assign issue     = (state_q == StIssue);
  assign last_pair = (row_q == AW'(ROWS - 1)) && (col_q == AW'(COLS - 1));
  assign handshake = bus.res_valid && bus.res_ready;
  assign last_pop  = handshake && (pop_cnt_q == NCW'(N - 1));

  always_comb begin
    tag_v_d[0] = issue;
    for (int k = 1; k < PIPE_LAT; k++) begin
      tag_v_d[k] = tag_v_q[k-1];
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StIssue;
            row_d   = '0;
            col_d   = '0;
          end
        end
        StIssue: begin
          if (last_pair) begin
            state_d = StDrain;
          end else if (col_q == AW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // Leave DRAIN on the edge that captures the final in-flight result.
        StDrain: if (tag_v_d == '0) state_d = StOut;
        StOut: begin
          if (last_pop) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
      pop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      if (bus.abort || state_q == StIdle) begin
        pop_cnt_q <= '0;
      end else if (handshake) begin
        pop_cnt_q <= pop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_row_q[k] <= '0;
        tag_col_q[k] <= '0;
      end
    end else begin
      tag_v_q      <= bus.abort ? '0 : tag_v_d;
      tag_row_q[0] <= row_q;
      tag_col_q[0] <= col_q;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_row_q[k] <= tag_row_q[k-1];
        tag_col_q[k] <= tag_col_q[k-1];
      end
    end
  end

  assign push_data = {tag_row_q[PIPE_LAT-1], tag_col_q[PIPE_LAT-1], bus.dp_result};

  ygb2_scheduler_res_fifo #(
    .W     (FW),
    .DEPTH (N)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.abort),
    .push      (tag_v_q[PIPE_LAT-1]),
    .push_data (push_data),
    .pop       (handshake),
    .out_valid (bus.res_valid),
    .out_data  (fifo_out)
  );

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.dp_issue = issue;
  assign bus.row_addr = row_q;
  assign bus.col_addr = col_q;
  assign {bus.res_row, bus.res_col, bus.res_data} = fifo_out;

endmodule
